// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache:
// geometry, derived field widths, FSM encoding and address field helpers.
package dcache_pkg;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CACHE_LINES = 32;
    localparam int unsigned BLOCK_WORDS = 4;

    localparam int unsigned INDEX_W = $clog2(CACHE_LINES);
    localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_e;

    // Word address layout is {tag, index, offset}
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0]   t,
                                                    input logic [INDEX_W-1:0] i,
                                                    input logic [OFF_W-1:0]   o);
        return {t, i, o};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache.
// Ports:
//   clk, rst_n                        clock, async active-low reset (clears valid bits only)
//   rd_index, rd_offset               combinational lookup address
//   rd_valid_c, rd_tag_c, rd_data_c   lookup results for the addressed line/word
//   wr_en, wr_index, wr_offset, wr_data   single-word write port
//   set_en, set_index, set_tag        marks a line valid and installs its tag
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFF_W-1:0]   rd_offset,
    output logic               rd_valid_c,
    output logic [TAG_W-1:0]   rd_tag_c,
    output logic [DATA_W-1:0]  rd_data_c,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [OFF_W-1:0]   wr_offset,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               set_en,
    input  logic [INDEX_W-1:0] set_index,
    input  logic [TAG_W-1:0]   set_tag
);

    logic [CACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
    logic [DATA_W-1:0]      data_q [CACHE_LINES][BLOCK_WORDS];

    // Valid bits are the only storage that reset touches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[set_index] <= set_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid_c = valid_q[rd_index];
    assign rd_tag_c   = tag_q[rd_index];
    assign rd_data_c  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, read-allocate data-cache controller for the
// single-cycle core. Load hits return data in the same cycle; misses refill a
// whole line beat by beat from main memory; stores always go through to memory
// and update the cached word only if the line is present.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   MemRead, MemWrite           load/store request from control unit (store wins)
//   Addr, WriteData             word address and store data
//   ReadData                    load data, valid when MemRead=1 and Stall=0
//   Stall                       freezes PC and RegWrite while the access is pending
//   mem_rd_req, mem_wr_req      level requests to main memory
//   mem_addr, mem_wdata         main-memory address / write data (stable per request)
//   mem_rdata, mem_ready        main-memory read data and one-cycle completion
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               mem_rd_req_d, mem_wr_req_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               stall_c;

    logic [ADDR_W-1:0]  lk_addr_c;
    logic               rd_valid_c;
    logic [TAG_W-1:0]   rd_tag_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               hit_c;

    logic               arr_wr_en;
    logic [INDEX_W-1:0] arr_wr_index;
    logic [OFF_W-1:0]   arr_wr_offset;
    logic [DATA_W-1:0]  arr_wr_data;
    logic               arr_set_en;
    logic [INDEX_W-1:0] arr_set_index;
    logic [TAG_W-1:0]   arr_set_tag;

    // mem_addr holds the latched request address outside IDLE, so it doubles
    // as the lookup address for the write-hit check and the refill target.
    assign lk_addr_c = (state_q == IDLE) ? Addr : mem_addr;
    assign hit_c     = rd_valid_c && (rd_tag_c == addr_tag(lk_addr_c));

    dcache_array u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index   (addr_index(lk_addr_c)),
        .rd_offset  (addr_offset(lk_addr_c)),
        .rd_valid_c (rd_valid_c),
        .rd_tag_c   (rd_tag_c),
        .rd_data_c  (rd_data_c),
        .wr_en      (arr_wr_en),
        .wr_index   (arr_wr_index),
        .wr_offset  (arr_wr_offset),
        .wr_data    (arr_wr_data),
        .set_en     (arr_set_en),
        .set_index  (arr_set_index),
        .set_tag    (arr_set_tag)
    );

    assign ReadData = rd_data_c;
    // Never stall the core while it is held in reset
    assign Stall    = rst_n & stall_c;

    // State and memory-interface registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            mem_rd_req <= mem_rd_req_d;
            mem_wr_req <= mem_wr_req_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    // Next-state, handshake and array-update decode
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        mem_rd_req_d  = mem_rd_req;
        mem_wr_req_d  = mem_wr_req;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        stall_c       = 1'b0;
        arr_wr_en     = 1'b0;
        arr_wr_index  = addr_index(mem_addr);
        arr_wr_offset = beat_q;
        arr_wr_data   = mem_rdata;
        arr_set_en    = 1'b0;
        arr_set_index = addr_index(mem_addr);
        arr_set_tag   = addr_tag(mem_addr);

        unique case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    stall_c      = 1'b1;
                    state_d      = WRITE;
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = Addr;
                    mem_wdata_d  = WriteData;
                end else if (MemRead && !hit_c) begin
                    stall_c      = 1'b1;
                    state_d      = REFILL;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = make_addr(addr_tag(Addr), addr_index(Addr), OFF_W'(0));
                    beat_d       = '0;
                end
            end

            REFILL: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    arr_wr_en  = 1'b1;
                    beat_d     = beat_q + OFF_W'(1);
                    mem_addr_d = make_addr(addr_tag(mem_addr), addr_index(mem_addr),
                                           beat_q + OFF_W'(1));
                    if (beat_q == OFF_W'(BLOCK_WORDS - 1)) begin
                        arr_set_en   = 1'b1;
                        mem_rd_req_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end

            WRITE: begin
                stall_c = !mem_ready;
                if (mem_ready) begin
                    mem_wr_req_d = 1'b0;
                    state_d      = IDLE;
                    // Write-through without allocate: only touch a resident line
                    if (hit_c) begin
                        arr_wr_en     = 1'b1;
                        arr_wr_offset = addr_offset(mem_addr);
                        arr_wr_data   = mem_wdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized, scoreboard-checked bench for dcache_controller with a
// behavioural memory responder and a line-level reference cache model.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [9:0]  Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        mem_rd_req, mem_wr_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    typedef struct {
        bit          is_load;
        int          addr;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference: flat memory image plus per-line presence (valid, tag)
    logic [31:0] ref_mem [1024];
    bit          ref_valid [32];
    int          ref_tag [32];

    // Memory responder state
    logic [31:0] mem_arr [1024];
    int          fixed_lat = 0;
    int          cnt = 0;
    int          rd_beat = 0;
    int          rd_cyc_tot = 0;
    int          wr_cyc_tot = 0;
    int          beat_tot = 0;

    int          cur_addr = 0;
    logic [31:0] cur_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
        finish_run();
    endtask

    // Slow memory: random (or fixed) latency per beat, ready for one cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            cnt       = 0;
            rd_beat   = 0;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (mem_rd_req || mem_wr_req) begin
                if (mem_rd_req) rd_cyc_tot++;
                else            wr_cyc_tot++;
                if (cnt == 0) cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    if (mem_wr_req) begin
                        chk("wr_addr", 32'(mem_addr), 32'(cur_addr));
                        chk("wr_data", mem_wdata, cur_data);
                        mem_arr[mem_addr] = mem_wdata;
                    end else begin
                        chk("refill_addr", 32'(mem_addr), 32'((cur_addr / 4) * 4 + rd_beat));
                        mem_rdata = mem_arr[mem_addr];
                        beat_tot++;
                        rd_beat = (rd_beat + 1) % 4;
                    end
                end
            end
        end
    end

    // Monitor: an access completes when the request is up and Stall is low
    int stall_cnt = 0;
    int s_rd = 0, s_wr = 0, s_beat = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            stall_cnt = 0;
            s_rd = rd_cyc_tot; s_wr = wr_cyc_tot; s_beat = beat_tot;
        end else if (MemRead || MemWrite) begin
            if (Stall) begin
                stall_cnt++;
            end else begin
                if (sbq.size() == 0) begin
                    chk("sb_nonempty", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_load) begin
                        chk("load_data", ReadData, e.data);
                        if (e.hit) begin
                            chk("hit_stall", 32'(stall_cnt), 32'd0);
                            chk("hit_beats", 32'(beat_tot - s_beat), 32'd0);
                        end else begin
                            chk("miss_beats", 32'(beat_tot - s_beat), 32'd4);
                            chk("miss_stall", 32'(stall_cnt), 32'(1 + rd_cyc_tot - s_rd));
                        end
                    end else begin
                        chk("store_stall", 32'(stall_cnt), 32'(wr_cyc_tot - s_wr));
                        chk("store_beats", 32'(beat_tot - s_beat), 32'd0);
                    end
                end
                stall_cnt = 0;
                s_rd = rd_cyc_tot; s_wr = wr_cyc_tot; s_beat = beat_tot;
            end
        end
    end

    // Issue one access, predict its outcome, and wait for it to retire
    task automatic do_op(input bit rd, input bit wr, input int a, input logic [31:0] d);
        exp_t e;
        int   idx, tg;
        bit   done;
        idx = (a / 4) % 32;
        tg  = a / 128;
        e.addr = a;
        if (wr) begin
            e.is_load  = 1'b0;
            e.data     = d;
            e.hit      = 1'b0;
            ref_mem[a] = d;
        end else begin
            e.is_load      = 1'b1;
            e.hit          = ref_valid[idx] && (ref_tag[idx] == tg);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            e.data         = ref_mem[a];
        end
        sbq.push_back(e);
        cur_addr  = a;
        cur_data  = d;
        MemRead   = rd;
        MemWrite  = wr;
        Addr      = 10'(a);
        WriteData = d;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #2;
            if (!Stall) done = 1'b1;
        end
        if (!done) timeout("op_complete");
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic idle_cycle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk); #2;
        chk("idle_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        sbq.delete();
    endtask

    // Start a refill, then pull reset while the third beat is outstanding
    task automatic reset_mid_refill(input int a);
        bit got;
        cur_addr = a;
        Addr     = 10'(a);
        MemRead  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); #2;
            if (rd_beat == 2) got = 1'b1;
        end
        if (!got) timeout("reach_beat2");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        MemRead = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int a, r;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'(i + 'h100);
            mem_arr[i] = 32'(i + 'h100);
        end
        MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        apply_reset();
        #1;
        chk("reset_stall", 32'(Stall), 32'd0);
        chk("reset_rd_req", 32'(mem_rd_req), 32'd0);
        chk("reset_wr_req", 32'(mem_wr_req), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;

        // Directed scenarios
        fixed_lat = 3;
        do_op(1'b1, 1'b0, 'h014, 32'h0);          // cold miss, 4-beat refill
        do_op(1'b1, 1'b0, 'h016, 32'h0);          // hit in the fresh line
        fixed_lat = 2;
        do_op(1'b0, 1'b1, 'h015, 32'hDEADBEEF);   // store hit, write-through
        do_op(1'b1, 1'b0, 'h015, 32'h0);
        do_op(1'b0, 1'b1, 'h3F0, 32'hCAFEF00D);   // store miss, no allocate
        do_op(1'b1, 1'b0, 'h3F0, 32'h0);          // still a miss
        do_op(1'b1, 1'b0, 'h214, 32'h0);          // evicts the 0x014 line
        do_op(1'b1, 1'b0, 'h014, 32'h0);          // misses again
        do_op(1'b1, 1'b1, 'h017, 32'h12345678);   // both asserted: treated as store
        do_op(1'b1, 1'b0, 'h017, 32'h0);
        idle_cycle();
        fixed_lat = 0;
        reset_mid_refill('h214);
        do_op(1'b1, 1'b0, 'h214, 32'h0);          // full refill after reset
        do_op(1'b1, 1'b0, 'h215, 32'h0);

        // Randomized traffic over a small footprint so lines collide and hit
        for (int n = 0; n < 150; n++) begin
            a = int'($urandom_range(0, 7)) * 128 + int'($urandom_range(0, 7)) * 4
                + int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if (r < 60)      do_op(1'b1, 1'b0, a, 32'h0);
            else if (r < 90) do_op(1'b0, 1'b1, a, 32'($urandom));
            else if (r < 95) do_op(1'b1, 1'b1, a, 32'($urandom));
            else             idle_cycle();
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        finish_run();
    end

endmodule
